// File: rtl/hmove_player.sv
// Automated human-side player for the tic-tac-toe move FSM: presses enter/new_game
// like the board buttons would, follows a short move script and tracks both boards.
`timescale 1ns/1ps
module hmove_player #(
  parameter int PRESS_CYCLES = 4,
  parameter int SETUP_CYCLES = 3,
  parameter int TIMEOUT      = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] script,
  input  logic [2:0]  script_len,
  input  logic [3:0]  cMove,
  input  logic        win,
  output logic [3:0]  hMove,
  output logic        enter_L,
  output logic        new_game_L,
  output logic        busy,
  output logic        done,
  output logic        game_won,
  output logic        timeout_err,
  output logic        illegal_err,
  output logic [8:0]  board_h,
  output logic [8:0]  board_c,
  output logic [2:0]  move_count
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SNAP, S_SETUP, S_PRESS, S_RELEASE, S_WAIT_RESP,
    S_RECORD, S_NG_PRESS, S_NG_RELEASE, S_WAIT_START, S_DONE
  } state_t;

  state_t        r_state, w_next;
  logic [TW-1:0] r_tmr;
  logic [TW-1:0] w_tmr_inc;
  logic [15:0]   r_script;
  logic [2:0]    r_len;
  logic          r_ack;
  logic [3:0]    r_hmove;
  logic          r_won, r_to, r_ill;
  logic [8:0]    r_board_h, r_board_c;
  logic [2:0]    r_mcount;

  logic [3:0]    w_nibble;
  logic [8:0]    w_occ;
  logic          w_nib_ok, w_cm_range, w_cm_ok, w_to_hit;
  logic          w_set_ill, w_set_to, w_set_won, w_commit_h;
  logic [8:0]    w_c_set;

  function automatic logic [8:0] sq_mask(input logic [3:0] sq);
    if (sq >= 4'd1 && sq <= 4'd9) return 9'd1 << (sq - 4'd1);
    return 9'd0;
  endfunction

  assign w_nibble   = r_script[{r_mcount[1:0], 2'b00} +: 4];
  assign w_occ      = r_board_h | r_board_c;
  assign w_nib_ok   = (w_nibble >= 4'd1) && (w_nibble <= 4'd9) && ((sq_mask(w_nibble) & w_occ) == 9'd0);
  assign w_cm_range = (cMove >= 4'd1) && (cMove <= 4'd9);
  assign w_cm_ok    = w_cm_range && ((sq_mask(cMove) & w_occ) == 9'd0);
  // Saturating timer; the timeout compare is on equality with the incremented value.
  assign w_tmr_inc  = (r_tmr == TW'(TIMEOUT)) ? r_tmr : r_tmr + 1'b1;
  assign w_to_hit   = (w_tmr_inc == TW'(TIMEOUT));

  always_comb begin
    w_next     = r_state;
    w_set_ill  = 1'b0;
    w_set_to   = 1'b0;
    w_set_won  = 1'b0;
    w_commit_h = 1'b0;
    w_c_set    = 9'd0;
    case (r_state)
      S_IDLE:       if (start) w_next = S_SNAP;
      S_SNAP: begin
        if (w_cm_range) begin
          w_c_set = sq_mask(cMove);
          w_next  = S_SETUP;
        end else begin
          w_set_ill = 1'b1;
          w_next    = S_NG_PRESS;
        end
      end
      S_SETUP: begin
        if (!w_nib_ok) begin
          w_set_ill = 1'b1;
          w_next    = S_NG_PRESS;
        end else if (r_tmr == TW'(SETUP_CYCLES - 1)) begin
          w_next = S_PRESS;
        end
      end
      S_PRESS: begin
        if (r_tmr == TW'(PRESS_CYCLES - 1)) begin
          w_commit_h = 1'b1;
          w_next     = S_RELEASE;
        end
      end
      S_RELEASE:    w_next = S_WAIT_RESP;
      S_WAIT_RESP: begin
        if (r_ack && cMove != 4'd0) begin
          w_next = S_RECORD;
        end else if (w_to_hit) begin
          w_set_to = 1'b1;
          w_next   = S_NG_PRESS;
        end
      end
      S_RECORD: begin
        if (!w_cm_ok) begin
          w_set_ill = 1'b1;
          w_next    = S_NG_PRESS;
        end else begin
          w_c_set = sq_mask(cMove);
          if (win) begin
            w_set_won = 1'b1;
            w_next    = S_NG_PRESS;
          end else if (r_mcount == r_len) begin
            w_next = S_NG_PRESS;
          end else begin
            w_next = S_SETUP;
          end
        end
      end
      S_NG_PRESS:   if (r_tmr == TW'(PRESS_CYCLES - 1)) w_next = S_NG_RELEASE;
      S_NG_RELEASE: w_next = S_WAIT_START;
      S_WAIT_START: begin
        if (cMove == 4'd5 && !win) begin
          w_next = S_DONE;
        end else if (w_to_hit) begin
          w_set_to = 1'b1;
          w_next   = S_DONE;
        end
      end
      S_DONE:       w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_tmr     <= '0;
      r_script  <= 16'd0;
      r_len     <= 3'd1;
      r_ack     <= 1'b0;
      r_hmove   <= 4'd0;
      r_won     <= 1'b0;
      r_to      <= 1'b0;
      r_ill     <= 1'b0;
      r_board_h <= 9'd0;
      r_board_c <= 9'd0;
      r_mcount  <= 3'd0;
    end else begin
      r_state <= w_next;
      r_tmr   <= (w_next != r_state) ? '0 : w_tmr_inc;
      if (r_state == S_IDLE && start) begin
        r_script  <= script;
        r_len     <= (script_len == 3'd0 || script_len > 3'd4) ? 3'd1 : script_len;
        r_won     <= 1'b0;
        r_to      <= 1'b0;
        r_ill     <= 1'b0;
        r_board_h <= 9'd0;
        r_board_c <= 9'd0;
        r_mcount  <= 3'd0;
      end else begin
        r_ill     <= r_ill | w_set_ill;
        r_to      <= r_to | w_set_to;
        r_won     <= r_won | w_set_won;
        r_board_c <= r_board_c | w_c_set;
        if (w_commit_h) begin
          r_board_h <= r_board_h | sq_mask(r_hmove);
          r_mcount  <= r_mcount + 3'd1;
        end
      end
      // hMove only moves on entry to SETUP or NG_PRESS, both with enter_L high.
      if (w_next == S_SETUP && r_state != S_SETUP) r_hmove <= w_nibble;
      else if (w_next == S_NG_PRESS && r_state != S_NG_PRESS) r_hmove <= 4'd0;
      if (w_next == S_PRESS && r_state != S_PRESS) r_ack <= 1'b0;
      else if (r_state == S_PRESS && cMove == 4'd0) r_ack <= 1'b1;
    end
  end

  assign hMove       = r_hmove;
  assign enter_L     = (r_state != S_PRESS);
  assign new_game_L  = (r_state != S_NG_PRESS);
  assign busy        = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done        = (r_state == S_DONE);
  assign game_won    = r_won;
  assign timeout_err = r_to;
  assign illegal_err = r_ill;
  assign board_h     = r_board_h;
  assign board_c     = r_board_c;
  assign move_count  = r_mcount;

endmodule

// File: tb/tb_hmove_player.sv
// Bench for hmove_player: a behavioural move-FSM responder, a press scoreboard,
// a table of scripted games and hand-written timeout / reset / busy sequences.
`timescale 1ns/1ps
module tb_hmove_player;
  localparam int TIMEOUT = 64;

  logic        clock = 1'b0, reset = 1'b1, start = 1'b0, win = 1'b0;
  logic [15:0] script = 16'd0;
  logic [2:0]  script_len = 3'd0;
  logic [3:0]  cMove = 4'd5;
  logic [3:0]  hMove;
  logic        enter_L, new_game_L, busy, done, game_won, timeout_err, illegal_err;
  logic [8:0]  board_h, board_c;
  logic [2:0]  move_count;

  hmove_player #(.PRESS_CYCLES(4), .SETUP_CYCLES(3), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .start(start), .script(script), .script_len(script_len),
    .cMove(cMove), .win(win), .hMove(hMove), .enter_L(enter_L), .new_game_L(new_game_L),
    .busy(busy), .done(done), .game_won(game_won), .timeout_err(timeout_err),
    .illegal_err(illegal_err), .board_h(board_h), .board_c(board_c), .move_count(move_count));

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] script;
    logic [2:0]  len;
    logic [15:0] reps;
    int          win_idx;
    int          presses;
    logic [8:0]  exp_h;
    logic [8:0]  exp_c;
    logic [2:0]  exp_mc;
    logic        exp_won;
    logic        exp_ill;
    logic        exp_to;
  } vec_t;

  vec_t        vecs[8];
  int          n_checks = 0, n_err = 0, n_done = 0, viol = 0;
  logic [3:0]  exp_q[$];

  // responder state
  logic [15:0] reps = 16'd0;
  int          win_idx = 7, ridx = 0, zcnt = 0, rcnt = 0, ncnt = 0;
  bit          stall = 1'b0;
  logic        prev_en = 1'b1, prev_ng = 1'b1, mon_pe = 1'b1;
  logic [3:0]  mon_ph = 4'd0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Behaves like the move FSM: shows 0 while digesting a press, then a reply; 5 after new game.
  initial begin : responder
    forever begin
      tick();
      if (zcnt > 0) begin zcnt--; if (zcnt == 0) cMove = 4'd0; end
      if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) begin
          cMove = reps[ridx*4 +: 4];
          win   = (ridx == win_idx);
          ridx++;
        end
      end
      if (ncnt > 0) begin ncnt--; if (ncnt == 0) begin cMove = 4'd5; win = 1'b0; end end
      if (prev_en && !enter_L) zcnt = 1;
      if (!prev_en && enter_L && !stall) rcnt = 2;
      if (!prev_ng && new_game_L) ncnt = 2;
      prev_en = enter_L;
      prev_ng = new_game_L;
    end
  end

  initial begin : monitor
    forever begin
      tick();
      if (done) n_done++;
      if (!enter_L && !new_game_L) viol++;
      if (!enter_L && !mon_pe && hMove !== mon_ph) viol++;
      if (mon_pe && !enter_L) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_press: hMove=%0d pressed with no move expected", hMove);
        end else begin
          check("press_hmove", 32'(hMove), 32'(exp_q.pop_front()));
        end
      end
      mon_pe = enter_L;
      mon_ph = hMove;
    end
  end

  task automatic pulse_start(input logic [15:0] s, input logic [2:0] l);
    script = s; script_len = l; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      tick();
      if (done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic run_game(input vec_t v, input string tag);
    n_done = 0; viol = 0; ridx = 0; reps = v.reps; win_idx = v.win_idx; stall = 1'b0;
    for (int i = 0; i < v.presses; i++) exp_q.push_back(v.script[i*4 +: 4]);
    pulse_start(v.script, v.len);
    wait_done(tag);
    repeat (3) tick();
    check({tag, "_board_h"},    32'(board_h),     32'(v.exp_h));
    check({tag, "_board_c"},    32'(board_c),     32'(v.exp_c));
    check({tag, "_move_count"}, 32'(move_count),  32'(v.exp_mc));
    check({tag, "_game_won"},   32'(game_won),    32'(v.exp_won));
    check({tag, "_illegal"},    32'(illegal_err), 32'(v.exp_ill));
    check({tag, "_timeout"},    32'(timeout_err), 32'(v.exp_to));
    check({tag, "_done_once"},  32'(n_done),      32'd1);
    check({tag, "_presses"},    32'(exp_q.size()), 32'd0);
    check({tag, "_invariants"}, 32'(viol),        32'd0);
    check({tag, "_busy_low"},   32'(busy),        32'd0);
  endtask

  initial begin : main
    bit found;
    int ng_low;
    vecs[0] = '{16'h0796, 3'd3, 16'h0231, 2, 3, 9'h160, 9'h017, 3'd3, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{16'h0026, 3'd2, 16'h0091, 1, 2, 9'h022, 9'h111, 3'd2, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'h0006, 3'd1, 16'h0006, 7, 1, 9'h020, 9'h010, 3'd1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{16'h0015, 3'd2, 16'h0000, 7, 0, 9'h000, 9'h010, 3'd0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{16'h0003, 3'd0, 16'h0004, 7, 1, 9'h004, 9'h018, 3'd1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{16'h4321, 3'd4, 16'h6789, 7, 4, 9'h00F, 9'h1F0, 3'd4, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{16'h0007, 3'd6, 16'h0008, 7, 1, 9'h040, 9'h090, 3'd1, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{16'h0001, 3'd1, 16'h000C, 7, 1, 9'h001, 9'h010, 3'd1, 1'b0, 1'b1, 1'b0};

    repeat (3) tick();
    check("rst_hmove", 32'(hMove), 32'd0);
    check("rst_enter_L", 32'(enter_L), 32'd1);
    check("rst_new_game_L", 32'(new_game_L), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_flags", 32'({game_won, timeout_err, illegal_err}), 32'd0);
    check("rst_boards", 32'({board_h, board_c}), 32'd0);
    check("rst_move_count", 32'(move_count), 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) run_game(vecs[i], $sformatf("v%0d", i));

    // Responder never answers the first press: timeout exactly TIMEOUT cycles into WAIT_RESP.
    n_done = 0; ridx = 0; stall = 1'b1; viol = 0;
    exp_q.push_back(4'd6);
    pulse_start(16'h0006, 3'd1);
    found = 1'b0;
    begin
      bit low = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
        tick();
        if (!enter_L) low = 1'b1;
        else if (low) found = 1'b1;
      end
    end
    check("to_enter_released", 32'(found), 32'd1);
    for (int k = 1; k <= TIMEOUT + 1; k++) begin
      tick();
      if (k == TIMEOUT) check("to_not_yet", 32'(timeout_err), 32'd0);
      if (k == TIMEOUT + 1) check("to_flag", 32'(timeout_err), 32'd1);
    end
    ng_low = 0;
    for (int j = 0; j < 5; j++) begin
      if (!new_game_L) ng_low++;
      if (j < 4) tick();
    end
    check("to_ng_low_cycles", 32'(ng_low), 32'd4);
    wait_done("to");
    repeat (3) tick();
    check("to_done_once", 32'(n_done), 32'd1);
    check("to_illegal", 32'(illegal_err), 32'd0);
    check("to_move_count", 32'(move_count), 32'd1);
    check("to_invariants", 32'(viol), 32'd0);
    stall = 1'b0;

    // Second start while busy must not restart the game.
    n_done = 0; ridx = 0; reps = 16'h6789; win_idx = 7;
    for (int i = 0; i < 4; i++) exp_q.push_back(4'(i + 1));
    pulse_start(16'h4321, 3'd4);
    found = 1'b0;
    for (int k = 0; k < 500 && !found; k++) begin
      tick();
      if (move_count == 3'd2) found = 1'b1;
    end
    check("busy_reached_mc2", 32'(found), 32'd1);
    pulse_start(16'h0005, 3'd1);
    wait_done("busy");
    repeat (3) tick();
    check("busy_move_count", 32'(move_count), 32'd4);
    check("busy_board_h", 32'(board_h), 32'h00F);
    check("busy_board_c", 32'(board_c), 32'h1F0);
    check("busy_done_once", 32'(n_done), 32'd1);

    // Reset in the middle of a press, with a start pulse in the same cycle.
    ridx = 0; reps = 16'h0231; win_idx = 2;
    exp_q.push_back(4'd6); exp_q.push_back(4'd9); exp_q.push_back(4'd7);
    pulse_start(16'h0796, 3'd3);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      tick();
      if (!enter_L) found = 1'b1;
    end
    check("rp_in_press", 32'(found), 32'd1);
    reset = 1'b1; start = 1'b1;
    tick();
    check("rp_enter_L", 32'(enter_L), 32'd1);
    check("rp_busy", 32'(busy), 32'd0);
    check("rp_hmove", 32'(hMove), 32'd0);
    check("rp_new_game_L", 32'(new_game_L), 32'd1);
    check("rp_boards", 32'({board_h, board_c}), 32'd0);
    check("rp_flags_mc", 32'({game_won, timeout_err, illegal_err, move_count}), 32'd0);
    reset = 1'b0; start = 1'b0;
    tick();
    check("rp_start_lost", 32'(busy), 32'd0);
    exp_q.delete();
    repeat (6) tick();
    cMove = 4'd5; win = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
